// File: rtl/rv_fetch_queue.sv
// ---------------------------------------------------------------------------
// rv_fetch_queue
//
// Decoupled in-order instruction prefetcher for the pipelined RISC-V core.
// Sequential fetch addresses go out on a request/grant handshake. Returned
// instructions are buffered with their PCs in a DEPTH-entry queue, and decode
// takes them through a valid/ready handshake. A redirect from execute flushes
// the queue, restarts fetch at the new PC and discards every response that is
// still outstanding.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   imem_req     fetch request valid
//   imem_addr    word-aligned fetch address
//   imem_gnt     memory accepted the request this cycle
//   imem_rvalid  response valid (responses return in request order)
//   imem_rdata   fetched instruction
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch PC (bits [1:0] ignored)
//   d_valid      head-of-queue instruction valid
//   d_instr      head instruction
//   d_pc         PC of the head instruction
//   d_ready      decode accepts the head this cycle
//   count        queue occupancy
// ---------------------------------------------------------------------------
module rv_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       d_valid,
    output logic [31:0]                d_instr,
    output logic [XLEN-1:0]            d_pc,
    input  logic                       d_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] rspPc_q, rspPc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;

    logic [31:0]     instrMem [DEPTH];
    logic [XLEN-1:0] pcMem    [DEPTH];

    logic            credit;
    logic            grantFire;
    logic            rspFire;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirectPcAligned;

    // Request credit: every queue slot is either occupied, or reserved by a
    // request whose response will be kept. Responses marked for dropping do
    // not consume a slot, so they are subtracted from the reservation.
    // A response with nothing in flight is a protocol error and is ignored.
    always_comb begin
        credit            = ({1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q}) < DEPTH_W;
        imem_req          = !reset && !redirect && credit;
        imem_addr         = fetchPc_q;
        grantFire         = imem_req && imem_gnt;
        rspFire           = imem_rvalid && (inflight_q != '0);
        d_valid           = !reset && (count_q != '0) && !redirect;
        d_instr           = instrMem[head_q];
        d_pc              = pcMem[head_q];
        count             = count_q;
        redirectPcAligned = {redirect_pc[XLEN-1:2], 2'b00};
    end

    // Next-state logic. A redirect overrides everything else in its cycle:
    // the queue empties, both PCs reload, and every outstanding response
    // (including one arriving right now) is marked to be discarded.
    always_comb begin
        fetchPc_d  = fetchPc_q;
        rspPc_d    = rspPc_q;
        drop_d     = drop_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        push       = 1'b0;
        pop        = 1'b0;
        inflight_d = inflight_q + CW'(grantFire) - CW'(rspFire);

        if (redirect) begin
            fetchPc_d = redirectPcAligned;
            rspPc_d   = redirectPcAligned;
            drop_d    = inflight_q - CW'(rspFire);
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
        end else begin
            if (grantFire) begin
                fetchPc_d = fetchPc_q + XLEN'(4);
            end
            if (rspFire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push    = 1'b1;
                    rspPc_d = rspPc_q + XLEN'(4);
                end
            end
            pop = d_valid && d_ready;
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc_q  <= RESET_PC;
            rspPc_q    <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetchPc_q  <= fetchPc_d;
            rspPc_q    <= rspPc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage has no reset; count and the pointers decide which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[tail_q] <= imem_rdata;
            pcMem[tail_q]    <= rspPc_q;
        end
    end

endmodule

// File: doc/rv_fetch_queue.md
Name: rv_fetch_queue

Overview:
Parametrised instruction-fetch front end for the pipelined RISC-V core. It replaces the single-instruction PC/Instr fetch path with a decoupled, in-order prefetcher: it generates sequential fetch addresses to instruction memory using a request/grant handshake, buffers returned instructions with their PCs in a DEPTH-entry queue, and presents them to decode with a valid/ready handshake. A redirect from execute flushes the queue and discards any in-flight responses.

Parameters:
XLEN, 32, address/PC width in bits.
DEPTH, 4, queue entries and the maximum requests in flight; power of 2, at least 2.
RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request valid.
imem_addr  out  XLEN  fetch address, word aligned.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  response data valid; responses return in request order.
imem_rdata  in  32  fetched instruction.
redirect  in  1  flush and restart fetch at redirect_pc.
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0.
d_valid  out  1  head-of-queue instruction valid.
d_instr  out  32  head instruction.
d_pc  out  XLEN  PC of the head instruction.
d_ready  in  1  decode accepts the head this cycle.
count  out  $clog2(DEPTH+1)  queue occupancy.

Behaviour:
- State registers: fetch_pc, rsp_pc, inflight (requests granted but not yet answered), drop (in-flight responses to discard, drop <= inflight), and the queue (instr and pc per entry, plus head/tail pointers and count).
- Reset (asynchronous): fetch_pc = rsp_pc = RESET_PC. inflight = drop = count = 0. Pointers = 0. Outputs: imem_req = 0 and d_valid = 0 while reset is asserted; count = 0.
- Request logic (combinational from registered state):
  - imem_req = !redirect && (count + inflight - drop < DEPTH).
  - imem_addr = fetch_pc.
- Grant: when imem_req && imem_gnt, fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN, and inflight increments.
- Response: when imem_rvalid, inflight decrements.
  - If drop > 0: drop decrements and the data is discarded.
  - Otherwise: {imem_rdata, rsp_pc} is pushed at the tail, and rsp_pc <= rsp_pc + 4 (wrapping).
  - imem_rvalid with inflight == 0 is a protocol error: it is ignored and the bench asserts on it.
- Decode side:
  - d_valid = (count != 0) && !redirect. d_instr and d_pc come from the head entry.
  - A pop occurs when d_valid && d_ready.
  - Queue-to-decode latency: a response written in cycle N is visible on d_valid in cycle N+1. There is no bypass.
  - A push and a pop in the same cycle leave count unchanged. The credit rule guarantees a push never occurs while the queue is full.
- Redirect (takes priority over all other updates in that cycle):
  - count <= 0 and head = tail = 0. No pop occurs that cycle.
  - fetch_pc and rsp_pc are loaded with {redirect_pc[XLEN-1:2], 2'b00}.
  - imem_req = 0 that cycle, so there is no grant.
  - drop <= inflight - (imem_rvalid ? 1 : 0). Every pending response is discarded, including any already marked for drop.
  - A response arriving in the redirect cycle is discarded and not pushed.
  - The first request to the new PC is issued the cycle after the redirect.
- Back-to-back redirects: each one reloads the PCs and recomputes drop. The last redirect wins.
- Reset mid-operation clears all counters. Late imem_rvalid pulses that follow reset then fall under the inflight == 0 rule above.
- Sustained throughput: one instruction per cycle when memory grants every cycle, rvalid follows 1 cycle after grant, and d_ready = 1.

Test Plan:
1. Release reset; memory grants every cycle with rvalid 1 cycle later, rdata = addr; d_ready = 1 -> imem_addr sequence 0x0, 0x4, 0x8, ...; first d_valid 2 cycles after the first grant with d_pc = 0x0, then one instruction per cycle with d_instr == d_pc.
2. DEPTH = 4, d_ready = 0 -> exactly 4 grants, then imem_req = 0 and count = 4. Raise d_ready -> the 4 entries pop in order 0x0 to 0xC, and fetching resumes at 0x10.
3. Memory with 3-cycle response latency, 2 requests in flight, redirect to 0x100 -> the 2 late responses are dropped, the next request is at 0x100, and the first d_pc after the redirect is 0x100.
4. Redirect in the same cycle as imem_rvalid and d_ready with count = 2 -> nothing pushed or popped, count = 0 the next cycle, and d_valid = 0 in the redirect cycle.
5. Redirect to 0x103 -> imem_addr = 0x100. Redirect to 0xFFFFFFFC (XLEN = 32) -> the next addresses are 0xFFFFFFFC then 0x0, and d_pc wraps identically.
6. Assert reset asynchronously mid-stream with count = 3 and inflight = 2 -> d_valid, imem_req and count go to 0 immediately. After release, fetch restarts at RESET_PC and stray rvalid pulses are ignored.
